// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute-stage issue sequencer:
// funct codes, FSM state encoding and default geometry.
package vec_pkg;

    localparam int LANES_DEF = 8;
    localparam int DW_DEF    = 32;
    localparam int VA_W_DEF  = 5;

    localparam logic [5:0] ADD_V = 6'b110000;
    localparam logic [5:0] SUB_V = 6'b110001;
    localparam logic [5:0] AND_V = 6'b110010;
    localparam logic [5:0] OR_V  = 6'b110011;
    localparam logic [5:0] XOR_V = 6'b110100;
    localparam logic [5:0] MUL_V = 6'b110101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_vec_op(input logic [5:0] funct);
        logic ok;
        case (funct)
            ADD_V, SUB_V, AND_V, OR_V, XOR_V, MUL_V: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational add/sub/and/or/xor unit; any other funct
// (including MUL_V, which goes to the shared multiplier) yields zero.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [5:0]    funct,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    // Lane operation select
    always_comb begin
        y = {DW{1'b0}};
        case (funct)
            ADD_V:   y = a + b;
            SUB_V:   y = a - b;
            AND_V:   y = a & b;
            OR_V:    y = a | b;
            XOR_V:   y = a ^ b;
            default: y = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/vec_op_sequencer.sv
// Vector issue sequencer: one instruction at a time, single-cycle logic ops
// across all lanes, MUL_V serialised through one shared multiplier.
module vec_op_sequencer
    import vec_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int VA_W  = VA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_funct,
    input  logic                in_bcast,
    input  logic [DW-1:0]       in_scalar,
    input  logic [LANES*DW-1:0] in_va,
    input  logic [LANES*DW-1:0] in_vb,
    input  logic [VA_W-1:0]     in_vd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [VA_W-1:0]     out_vd,
    output logic                out_err,
    output logic                busy
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW = LANES * DW;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [VW-1:0]   a_r;
    logic [VW-1:0]   b_r;
    logic [VW-1:0]   res_r;
    logic [5:0]      funct_r;
    logic [VA_W-1:0] vd_r;
    logic            err_r;

    logic            accept_s;
    logic            mul_last_s;
    logic [VW-1:0]   b_in_s;
    logic [VW-1:0]   alu_y_s;
    logic [DW-1:0]   mul_a_s;
    logic [DW-1:0]   mul_b_s;
    logic [DW-1:0]   mul_p_s;

    assign accept_s   = in_valid && (state_r == IDLE);
    assign mul_last_s = (cnt_r == CW'(LANES - 1));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign b_in_s[k*DW +: DW] = in_bcast ? in_scalar : in_vb[k*DW +: DW];

        vec_lane_alu #(.DW(DW)) u_alu (
            .funct (in_funct),
            .a     (in_va[k*DW +: DW]),
            .b     (b_in_s[k*DW +: DW]),
            .y     (alu_y_s[k*DW +: DW])
        );
    end

    // Shared multiplier operand mux, indexed by the lane counter
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {DW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (cnt_r == CW'(k)) begin
                mul_a_s = a_r[k*DW +: DW];
                mul_b_s = b_r[k*DW +: DW];
            end else begin
                mul_a_s = mul_a_s;
                mul_b_s = mul_b_s;
            end
        end
    end

    // Only the low DW product bits are kept, valid for signed and unsigned
    assign mul_p_s = mul_a_s * mul_b_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = (in_funct == MUL_V) ? MUL : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand latch, result register and lane counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {VW{1'b0}};
            b_r     <= {VW{1'b0}};
            res_r   <= {VW{1'b0}};
            funct_r <= 6'd0;
            vd_r    <= {VA_W{1'b0}};
            err_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            a_r     <= in_va;
            b_r     <= b_in_s;
            funct_r <= in_funct;
            vd_r    <= in_vd;
            err_r   <= !is_vec_op(in_funct);
            // ALU yields zero for MUL_V and unsupported codes alike
            res_r   <= alu_y_s;
            cnt_r   <= {CW{1'b0}};
        end else if ((state_r == MUL) && (funct_r == MUL_V)) begin
            for (int k = 0; k < LANES; k++) begin
                if (cnt_r == CW'(k)) begin
                    res_r[k*DW +: DW] <= mul_p_s;
                end
            end
            cnt_r <= mul_last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r == DONE);
    assign out_data  = res_r;
    assign out_vd    = vd_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Randomised self-checking bench for vec_op_sequencer against a lane-wise
// arithmetic reference model.
module tb_vec_op_sequencer;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int VA_W  = 5;
    localparam int VW    = LANES * DW;

    localparam logic [5:0] F_ADD = 6'b110000;
    localparam logic [5:0] F_SUB = 6'b110001;
    localparam logic [5:0] F_AND = 6'b110010;
    localparam logic [5:0] F_OR  = 6'b110011;
    localparam logic [5:0] F_XOR = 6'b110100;
    localparam logic [5:0] F_MUL = 6'b110101;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_funct;
    logic            in_bcast;
    logic [DW-1:0]   in_scalar;
    logic [VW-1:0]   in_va;
    logic [VW-1:0]   in_vb;
    logic [VA_W-1:0] in_vd;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   out_data;
    logic [VA_W-1:0] out_vd;
    logic            out_err;
    logic            busy;

    int total;
    int bad;

    vec_op_sequencer #(.LANES(LANES), .DW(DW), .VA_W(VA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct  (in_funct),
        .in_bcast  (in_bcast),
        .in_scalar (in_scalar),
        .in_va     (in_va),
        .in_vb     (in_vb),
        .in_vd     (in_vd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_vd    (out_vd),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] ref_result(input logic [5:0] f, input logic bc,
                                                 input logic [DW-1:0] sc,
                                                 input logic [VW-1:0] va, input logic [VW-1:0] vb);
        logic [VW-1:0] r;
        longint unsigned a, b, m;
        m = 64'h1_0000_0000;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            a = longint'(va[k*DW +: DW]);
            b = bc ? longint'(sc) : longint'(vb[k*DW +: DW]);
            case (f)
                F_ADD:   r[k*DW +: DW] = DW'((a + b) % m);
                F_SUB:   r[k*DW +: DW] = DW'((a + m - b) % m);
                F_AND:   r[k*DW +: DW] = DW'(a & b);
                F_OR:    r[k*DW +: DW] = DW'(a | b);
                F_XOR:   r[k*DW +: DW] = DW'(a ^ b);
                F_MUL:   r[k*DW +: DW] = DW'((a * b) % m);
                default: r[k*DW +: DW] = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic known_op(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_XOR) || (f == F_MUL);
    endfunction

    // Drive garbage on the input side; must be ignored while not idle
    task automatic scramble_inputs();
        in_valid  = 1'($urandom_range(0, 1));
        in_funct  = 6'($urandom);
        in_bcast  = 1'($urandom_range(0, 1));
        in_scalar = $urandom;
        in_vd     = 5'($urandom);
        for (int k = 0; k < LANES; k++) begin
            in_va[k*DW +: DW] = $urandom;
            in_vb[k*DW +: DW] = $urandom;
        end
    endtask

    // Issue one instruction from a negedge with the sequencer idle and check it end to end
    task automatic run_op(input logic [5:0] f, input logic bc, input logic [DW-1:0] sc,
                          input logic [VW-1:0] va, input logic [VW-1:0] vb,
                          input logic [VA_W-1:0] vd, input int stall);
        logic [VW-1:0] exp;
        int lat;
        int n;
        exp = ref_result(f, bc, sc, va, vb);
        lat = (f == F_MUL) ? LANES + 1 : 1;
        check_eq("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_funct  = f;
        in_bcast  = bc;
        in_scalar = sc;
        in_va     = va;
        in_vb     = vb;
        in_vd     = vd;
        out_ready = (stall == 0);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            in_valid = 1'b0;
            if (out_valid === 1'b1) break;
            check_eq("busy_wait", {busy, in_ready}, 2'b10);
            scramble_inputs();
        end
        in_valid = 1'b0;
        check_eq("latency", n, lat);
        check_eq("data", out_data, exp);
        check_eq("err", out_err, !known_op(f));
        check_eq("vd", out_vd, vd);
        check_eq("done_flags", {busy, in_ready}, 2'b10);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("hold_valid", {out_valid, in_ready}, 2'b10);
            check_eq("hold_data", out_data, exp);
            check_eq("hold_vd_err", {out_vd, out_err}, {vd, !known_op(f)});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("back_idle", {out_valid, in_ready, busy}, 3'b010);
    endtask

    logic [VW-1:0]   va;
    logic [VW-1:0]   vb;
    logic [5:0]      rf;
    logic [VA_W-1:0] rvd;

    initial begin
        total = 0;
        bad   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_funct  = '0;
        in_bcast  = 1'b0;
        in_scalar = '0;
        in_va     = '0;
        in_vb     = '0;
        in_vd     = '0;
        out_ready = 1'b0;
        #1;
        check_eq("reset_flags", {in_ready, out_valid, busy, out_err}, 4'b1000);
        check_eq("reset_data", out_data, '0);
        check_eq("reset_vd", out_vd, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = DW'(k + 1);
            vb[k*DW +: DW] = DW'(10 * k);
        end
        run_op(F_ADD, 1'b0, '0, va, vb, 5'd3, 0);

        for (int k = 0; k < LANES; k++) va[k*DW +: DW] = 32'd3;
        run_op(F_SUB, 1'b1, 32'd5, va, vb, 5'd7, 0);

        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = 32'h0001_0000 + DW'(k);
            vb[k*DW +: DW] = 32'h0001_0000;
        end
        run_op(F_MUL, 1'b0, '0, va, vb, 5'd12, 0);

        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = $urandom;
            vb[k*DW +: DW] = $urandom;
        end
        run_op(F_XOR, 1'b0, '0, va, vb, 5'd21, 5);

        run_op(6'b000000, 1'b0, '0, va, vb, 5'd9, 0);
        run_op(F_ADD, 1'b0, '0, va, vb, 5'd10, 0);

        // Asynchronous reset in the middle of a multiply
        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = 32'h0001_0000 + DW'(k);
            vb[k*DW +: DW] = 32'h0001_0000;
        end
        in_valid  = 1'b1;
        in_funct  = F_MUL;
        in_bcast  = 1'b0;
        in_va     = va;
        in_vb     = vb;
        in_vd     = 5'd17;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_flags", {out_valid, busy, in_ready, out_err}, 4'b0010);
        check_eq("mid_rst_data", out_data, '0);
        check_eq("mid_rst_vd", out_vd, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = $urandom;
            vb[k*DW +: DW] = $urandom;
        end
        run_op(F_ADD, 1'b0, '0, va, vb, 5'd30, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 6))
                0:       rf = F_ADD;
                1:       rf = F_SUB;
                2:       rf = F_AND;
                3:       rf = F_OR;
                4:       rf = F_XOR;
                5:       rf = F_MUL;
                default: rf = 6'($urandom);
            endcase
            for (int k = 0; k < LANES; k++) begin
                va[k*DW +: DW] = $urandom;
                vb[k*DW +: DW] = $urandom;
            end
            rvd = 5'($urandom);
            run_op(rf, 1'($urandom_range(0, 1)), $urandom, va, vb, rvd, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
Issue/sequencing controller for the 8-lane vector execute stage. Accepts one vector instruction at a time over a valid/ready handshake and latches its operands.
- ADD_V/SUB_V/AND_V/OR_V/XOR_V: computed on all lanes in one cycle.
- MUL_V: computed on a single shared 32x32 multiplier, one lane per cycle, replacing eight parallel multipliers.
- Results are held on a valid/ready output until the writeback stage takes them.

Parameters:
LANES, 8, number of vector lanes (counter width = clog2(LANES)).
DW, 32, lane data width.
VA_W, 5, vector destination register address width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  instruction/operands valid.
in_ready  out  1  sequencer can accept (state IDLE).
in_funct  in  6  vector funct code.
in_bcast  in  1  1: operand B of every lane = in_scalar; 0: B = in_vb.
in_scalar  in  DW  scalar/immediate operand for broadcast.
in_va  in  LANES*DW  operand A, lane k at bits [k*DW +: DW].
in_vb  in  LANES*DW  operand B, same packing.
in_vd  in  VA_W  destination vector register.
out_valid  out  1  result valid.
out_ready  in  1  writeback accepts result.
out_data  out  LANES*DW  lane results, same packing.
out_vd  out  VA_W  destination echoed from accepted instruction.
out_err  out  1  accepted funct was not a supported vector op.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state, including mid-MUL): state=IDLE, lane counter=0, in_ready=1, out_valid=0, out_data=0, out_vd=0, out_err=0, busy=0. All latched operands cleared.
- Accept: occurs on the edge where in_valid && in_ready. At that edge latch A, B, funct and vd. B lanes = in_scalar when in_bcast=1. Inputs are don't-care after acceptance.
- States: IDLE, MUL, DONE.
  - IDLE, accept, funct=MUL_V: go to MUL with counter=0.
  - IDLE, accept, any other funct: go to DONE. out_data holds all lanes computed from the inputs in one cycle.
  - MUL: each cycle, lane[cnt] = low DW bits of A[cnt]*B[cnt]; cnt increments. When cnt=LANES-1, go to DONE. Counter does not wrap past LANES-1; it is cleared on leaving MUL.
  - DONE: out_valid=1. When out_ready=1, go to IDLE; out_valid drops the next cycle. out_data, out_vd and out_err are stable while out_valid=1 && !out_ready.
- Latency, acceptance at edge T:
  - Non-MUL: out_valid from T+1.
  - MUL_V: out_valid from T+1+LANES (T+9).
  - Minimum issue interval: 2 cycles (non-MUL), LANES+2 cycles (MUL) with out_ready held high.
- in_ready is 1 only in IDLE. There is no accept in the cycle DONE is consumed.
- Arithmetic: modulo 2^DW wrap. No overflow flag. Low product bits are identical for signed and unsigned operands. SUB_V = A-B.
- Lanes not yet computed during MUL are 0 in the internal result register. out_data is only meaningful while out_valid=1.
- Funct codes: ADD_V=110000, SUB_V=110001, AND_V=110010, OR_V=110011, XOR_V=110100, MUL_V=110101. Any other funct: result all zeros, out_err=1, 1-cycle path. out_err clears on the next acceptance.
- in_valid while not IDLE is ignored with no side effects.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package vec_pkg holds:
  - funct localparams ADD_V..MUL_V;
  - state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2);
  - LANES/DW defaults.
- One sub-module: vec_lane_alu, a combinational single-lane add/sub/and/or/xor unit, instantiated LANES times.
- The shared multiplier stays in the top level, with an operand mux indexed by the lane counter.

Test Plan:
- ADD_V, A lanes = k+1, B lanes = 10*k, bcast=0, out_ready=1 -> out_valid at T+1, lane k = 11k+1, out_err=0, back in IDLE at T+2.
- SUB_V with bcast=1, scalar=5, A lanes = 3 -> every lane = 0xFFFFFFFE.
- MUL_V, A lanes = 0x10000+k, B lanes = 0x10000 -> out_valid exactly at T+9, lane k = k<<16. busy high T+1..T+9, in_valid pulses during that window ignored.
- XOR_V with out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- funct=000000 -> out_data=0, out_err=1 at T+1. Next ADD_V clears out_err.
- rst pulse at T+4 of a MUL_V -> out_valid=0, busy=0, in_ready=1, out_data=0 immediately (async). A following ADD_V completes normally.
